// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10
  } uart_parity_e;

  localparam int unsigned MIN_BAUD_DIV = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO; pointers carry an extra wrap bit to tell full from empty.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic                          pop_i,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wptr_q, rptr_q;
  logic                  do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter with runtime divisor and 1/2 stop bits.
// Parity support is compiled in with UART_TX_PARITY_EN.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_WIDTH-1:0]       tx_byte_in,
  input  logic                        tx_drive,
  output logic                        tx_ready,
  input  logic [DIV_WIDTH-1:0]        baud_div,
  input  logic                        stop_two,
  input  logic [1:0]                  parity_mode,
  output logic                        tx_serial_out,
  output logic                        tx_active,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned   BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_tx_state_e        state_q, state_d;
  logic [DIV_WIDTH-1:0]  timer_q, timer_d, div_q, div_d, div_new;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, head;
  logic stop_sec_q, stop_sec_d, stop2_q, stop2_d;
  logic par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic line_q, line_d, active_q, active_d, done_q, done_d;
  logic fifo_full, fifo_empty, pop, frame_end, bit_end;
  logic par_en_new, par_odd_new;

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (tx_drive && tx_ready),
    .wdata_i (tx_byte_in),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

`ifdef UART_TX_PARITY_EN
  assign par_en_new  = (parity_mode == EVEN) || (parity_mode == ODD);
  assign par_odd_new = (parity_mode == ODD);
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
  assign par_en_new  = 1'b0;
  assign par_odd_new = 1'b0;
`endif

  assign tx_ready = !fifo_full;
  assign div_new  = (baud_div < DIV_WIDTH'(MIN_BAUD_DIV)) ? DIV_WIDTH'(MIN_BAUD_DIV) : baud_div;
  assign bit_end  = (timer_q == div_q - 1'b1);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_d      = bit_q;
    stop_sec_d = stop_sec_q;
    shift_d    = shift_q;
    div_d      = div_q;
    stop2_d    = stop2_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    pop        = 1'b0;
    frame_end  = 1'b0;
    if (state_q != IDLE) timer_d = bit_end ? '0 : timer_q + 1'b1;
    case (state_q)
      IDLE:   ;
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_sec_q) begin
            stop_sec_d = 1'b1;
          end else begin
            frame_end = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A frame end with a queued word chains straight into START so there is no idle gap.
    if ((state_q == IDLE || frame_end) && !fifo_empty) begin
      pop        = 1'b1;
      state_d    = START;
      timer_d    = '0;
      bit_d      = '0;
      stop_sec_d = 1'b0;
      shift_d    = head;
      div_d      = div_new;
      stop2_d    = stop_two;
      par_en_d   = par_en_new;
      par_bit_d  = (^head) ^ par_odd_new;
    end
  end

  // Line outputs are registered from the current state, so they trail the FSM by one cycle.
  always_comb begin
    line_d   = 1'b1;
    active_d = (state_q != IDLE);
    done_d   = frame_end;
    case (state_q)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_q[0];
      PARITY:  line_d = par_bit_q;
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_q      <= '0;
      stop_sec_q <= 1'b0;
      shift_q    <= '0;
      div_q      <= DIV_WIDTH'(MIN_BAUD_DIV);
      stop2_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      line_q     <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      stop_sec_q <= stop_sec_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      stop2_q    <= stop2_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      line_q     <= line_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign tx_serial_out = line_q;
  assign tx_active     = active_q;
  assign tx_done       = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: vector table plus frame scoreboard.
module tb_uart_tx_param;

  typedef struct {
    logic [7:0]  data;
    int unsigned div;
    bit          stop2;
    bit          par_en;
    bit          par_bit;
    int unsigned len;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    bit          stop2;
    logic [1:0]  pmode;
    int unsigned len;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  tx_byte_in;
  logic        tx_drive;
  logic        tx_ready;
  logic [15:0] baud_div;
  logic        stop_two;
  logic [1:0]  parity_mode;
  logic        tx_serial_out, tx_active, tx_done;
  logic [2:0]  fifo_level;

  logic [4:0]  d5_byte;
  logic        d5_drive, d5_ready, d5_line, d5_active, d5_done;
  logic [2:0]  d5_level;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  exp_t        sb[$];
  bit          mon_en = 1'b0;
  bit          mon_busy = 1'b0;
  bit          gap_chk = 1'b0;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .tx_byte_in(tx_byte_in), .tx_drive(tx_drive),
    .tx_ready(tx_ready), .baud_div(baud_div), .stop_two(stop_two),
    .parity_mode(parity_mode), .tx_serial_out(tx_serial_out), .tx_active(tx_active),
    .tx_done(tx_done), .fifo_level(fifo_level)
  );

  uart_tx_param #(.DATA_WIDTH(5), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .tx_byte_in(d5_byte), .tx_drive(d5_drive),
    .tx_ready(d5_ready), .baud_div(16'd3), .stop_two(1'b0),
    .parity_mode(2'b00), .tx_serial_out(d5_line), .tx_active(d5_active),
    .tx_done(d5_done), .fifo_level(d5_level)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic [15:0] div, input bit s2,
                              input logic [1:0] pm, input int unsigned len);
    exp_t e;
    e.data  = d;
    e.div   = (div < 16'd2) ? 2 : int'(div);
    e.stop2 = s2;
`ifdef UART_TX_PARITY_EN
    e.par_en = (pm == 2'b01) || (pm == 2'b10);
`else
    e.par_en = 1'b0;
`endif
    e.par_bit = (^d) ^ (pm == 2'b10);
    e.len     = len;
    return e;
  endfunction

  // Walks one frame cycle by cycle; entered on the negedge of the first start-bit cycle.
  task automatic check_frame(input exp_t e);
    bit          ok = 1'b1;
    logic [7:0]  got = '0;
    int unsigned bad_c = 0;
    logic        bad_l = 1'b0, bad_le = 1'b0, bad_d = 1'b0, bad_de = 1'b0;
    for (int unsigned c = 0; c < e.len; c++) begin
      int unsigned b;
      logic le, de;
      if (c > 0) @(negedge clk);
      b = c / e.div;
      if (b == 0)                      le = 1'b0;
      else if (b <= 8)                 le = e.data[b-1];
      else if (e.par_en && b == 9)     le = e.par_bit;
      else                             le = 1'b1;
      de = (c == e.len - 1);
      if (b >= 1 && b <= 8 && (c % e.div) == 0) got[b-1] = tx_serial_out;
      if (ok && (tx_serial_out !== le || tx_done !== de || tx_active !== 1'b1)) begin
        ok = 1'b0; bad_c = c; bad_l = tx_serial_out; bad_le = le; bad_d = tx_done; bad_de = de;
      end
    end
    vec_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL frame: data got %h expected %h; cycle %0d line %b expected %b, done %b expected %b",
               got, e.data, bad_c, bad_l, bad_le, bad_d, bad_de);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (tx_active === 1'b1 && tx_serial_out === 1'b0) begin
          mon_busy = 1'b1;
          if (sb.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            e = sb.pop_front();
            check_frame(e);
            while (gap_chk && sb.size() > 0) begin
              @(negedge clk);
              chk("b2b_gap_line", {tx_active, tx_serial_out}, 2'b10);
              e = sb.pop_front();
              check_frame(e);
            end
          end
          mon_busy = 1'b0;
        end else if (tx_done === 1'b1) begin
          chk("stray_done", 1, 0);
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input bit exp_acc, input exp_t e);
    tx_byte_in = d;
    tx_drive   = 1'b1;
    chk("tx_ready", tx_ready, exp_acc);
    if (exp_acc) sb.push_back(e);
    @(posedge clk); #1;
    tx_drive = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while ((sb.size() != 0 || mon_busy || tx_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_active(input int unsigned budget, output bit ok);
    int unsigned n = 0;
    while (tx_active !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (n < budget);
    if (!ok) chk("active_timeout", 1, 0);
  endtask

  initial begin : stim
    vec_t vt[6];
    bit   ok;
    int unsigned cnt, low_cnt, high_cnt, done_idx;

    vt[0] = '{8'hA5, 16'd4, 1'b0, 2'b00, 40};
    vt[1] = '{8'h3C, 16'd0, 1'b0, 2'b00, 20};
    vt[2] = '{8'hFF, 16'd1, 1'b1, 2'b00, 22};
    vt[3] = '{8'h00, 16'd3, 1'b1, 2'b00, 33};
    vt[4] = '{8'h5A, 16'd5, 1'b0, 2'b00, 50};
    vt[5] = '{8'h81, 16'd2, 1'b0, 2'b11, 20};

    reset_n = 1'b0; tx_drive = 1'b0; tx_byte_in = '0; baud_div = 16'd4;
    stop_two = 1'b0; parity_mode = 2'b00; d5_byte = '0; d5_drive = 1'b0;
    #23;
    chk("rst_line",   tx_serial_out, 1);
    chk("rst_active", tx_active, 0);
    chk("rst_done",   tx_done, 0);
    chk("rst_ready",  tx_ready, 1);
    chk("rst_level",  fifo_level, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk); #1;

    // First-frame latency: push on edge N
    push(8'hA5, 1'b1, mk(8'hA5, 16'd4, 1'b0, 2'b00, 40));
    @(negedge clk);
    chk("lat_n_level",  fifo_level, 1);
    chk("lat_n_active", tx_active, 0);
    @(negedge clk);
    chk("lat_n1_level", fifo_level, 0);
    chk("lat_n1_line",  {tx_active, tx_serial_out}, 2'b01);
    @(negedge clk);
    chk("lat_n2_line",  {tx_active, tx_serial_out}, 2'b10);
    wait_idle(200);

    for (int unsigned i = 0; i < 6; i++) begin
      baud_div = vt[i].div; stop_two = vt[i].stop2; parity_mode = vt[i].pmode;
      push(vt[i].data, 1'b1, mk(vt[i].data, vt[i].div, vt[i].stop2, vt[i].pmode, vt[i].len));
      wait_idle(300);
    end

    // Six pushes into a depth-4 FIFO while idle: five accepted, back-to-back
    baud_div = 16'd4; stop_two = 1'b0; parity_mode = 2'b00; gap_chk = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      logic [7:0] d;
      d = 8'h10 + 8'(i * 17);
      push(d, i < 5, mk(d, 16'd4, 1'b0, 2'b00, 40));
    end
    chk("full_level", fifo_level, 4);
    chk("full_ready", tx_ready, 0);
    wait_idle(400);

    // Divisor change mid-frame only affects the following frame
    push(8'hC3, 1'b1, mk(8'hC3, 16'd4, 1'b0, 2'b00, 40));
    push(8'h96, 1'b1, mk(8'h96, 16'd6, 1'b0, 2'b00, 60));
    wait_active(20, ok);
    baud_div = 16'd6;
    wait_idle(300);
    gap_chk = 1'b0;

`ifdef UART_TX_PARITY_EN
    begin
      exp_t e;
      baud_div = 16'd3; stop_two = 1'b0; parity_mode = 2'b01;
      e = mk(8'h07, 16'd3, 1'b0, 2'b01, 33); e.par_en = 1'b1; e.par_bit = 1'b1;
      push(8'h07, 1'b1, e);
      wait_idle(200);
      baud_div = 16'd2; stop_two = 1'b1; parity_mode = 2'b10;
      e = mk(8'h07, 16'd2, 1'b1, 2'b10, 24); e.par_en = 1'b1; e.par_bit = 1'b0;
      push(8'h07, 1'b1, e);
      wait_idle(200);
      parity_mode = 2'b00; stop_two = 1'b0;
    end
`endif

    // Reset in the middle of the data bits
    mon_en = 1'b0; baud_div = 16'd4;
    push(8'h00, 1'b1, mk(8'h00, 16'd4, 1'b0, 2'b00, 40));
    sb.delete();
    push(8'h00, 1'b1, mk(8'h00, 16'd4, 1'b0, 2'b00, 40));
    sb.delete();
    wait_active(20, ok);
    repeat (10) @(negedge clk);
    chk("pre_rst_line", tx_serial_out, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_line",   tx_serial_out, 1);
    chk("mid_rst_active", tx_active, 0);
    chk("mid_rst_level",  fifo_level, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_done === 1'b1 || tx_serial_out !== 1'b1 || tx_active !== 1'b0) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // DATA_WIDTH=5 instance, divisor 3: 0x1F gives 5 ones, 21-cycle frame
    d5_byte = 5'h1F; d5_drive = 1'b1;
    @(posedge clk); #1;
    d5_drive = 1'b0;
    cnt = 0;
    while (d5_active !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("dw5_started", cnt < 20, 1);
    low_cnt = 0; high_cnt = 0; done_idx = 99;
    for (int unsigned c = 0; c < 21; c++) begin
      if (c > 0) @(negedge clk);
      if (d5_line === 1'b0) low_cnt++;
      if (c >= 3 && c < 18 && d5_line === 1'b1) high_cnt++;
      if (d5_done === 1'b1) done_idx = c;
    end
    chk("dw5_start_cycles", low_cnt, 3);
    chk("dw5_data_ones",    high_cnt, 15);
    chk("dw5_done_at",      done_idx, 20);
    @(negedge clk);
    chk("dw5_idle_after",   {d5_active, d5_line}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
